trunc_pos_agc: RTL and testbench
================================

// Module: trunc_pos_agc
// PURPOSE
// Automatic truncation-position controller for the manual bit-select truncator. It measures
// the peak magnitude of the signed wide input over fixed windows of valid samples. After each
// window it steps trunc_pos by at most one bit toward the position that fits the peak into
// DATA_O_WIDTH bits without clipping. It sits beside the truncator and drives its trunc_pos
// input; it also flags per-sample clipping at the current position.
// PARAMETERS
// DATA_I_WIDTH  30    width of signed data_in
// DATA_O_WIDTH  12    width of truncated output; sets minimum position DATA_O_WIDTH-1
// POS_WIDTH     $clog2(DATA_I_WIDTH)  width of trunc_pos / init_pos
// WIN_LEN       1024  valid samples per measurement window (>=2)
// HYST          0     extra bits of margin required before stepping trunc_pos down
// LOCK_WINS     4     consecutive unchanged windows before locked asserts
// PORTS
// clk            in   1             system clock
// rst            in   1             asynchronous active-high reset
// data_in        in   DATA_I_WIDTH  signed two's-complement sample
// data_in_valid  in   1             sample qualifier
// enable         in   1             1 = run control loop, 0 = idle/hold
// init_pos       in   POS_WIDTH     position loaded on rising edge of enable
// trunc_pos      out  POS_WIDTH     registered position to truncator (MSB index kept)
// pos_update     out  1             1-cycle pulse when trunc_pos changes
// clip           out  1             registered: previous valid sample would clip at trunc_pos
// locked         out  1             position stable for LOCK_WINS windows
// BEHAVIOUR
// - Reset values: trunc_pos=DATA_I_WIDTH-1, pos_update=0, clip=0, locked=0, state IDLE,
//   win_cnt=0, peak=0, stable_cnt=0.
// - Magnitude: mag = data_in[MSB] ? ~data_in : data_in (one's-complement, no overflow);
//   p = index of highest set bit of mag (p=0 if mag=0). Sample fits iff p < trunc_pos.
// - clip: valid sample in cycle N -> clip=(p >= trunc_pos) in cycle N+1; 0 after an invalid cycle.
//   Computed in every state, including IDLE.
// - Clamp range: POS_MIN=DATA_O_WIDTH-1, POS_MAX=DATA_I_WIDTH-1. Any loaded/target value is
//   clamped into [POS_MIN, POS_MAX].
// - FSM:
//   IDLE: win_cnt/peak/stable_cnt cleared; trunc_pos held; locked=0.
//     On enable=1 -> MEASURE, and trunc_pos <= clamp(init_pos) at the same edge.
//   MEASURE: each valid sample: peak <= max(peak, mag), win_cnt++.
//     When the WIN_LEN-th valid sample is accepted -> UPDATE.
//   UPDATE (1 cycle): target = clamp(p_peak+1).
//     If target > trunc_pos: trunc_pos+1.
//     Else if target + HYST < trunc_pos: trunc_pos-1.
//     Else: hold.
//     A valid sample in this cycle is the first sample of the next window
//     (peak<=mag, win_cnt<=1); otherwise peak<=0, win_cnt<=0. Then -> MEASURE.
// - Latency: last window sample accepted at cycle N, UPDATE at N+1, new trunc_pos and
//   pos_update=1 visible at N+2. pos_update only pulses when the value actually changes.
// - Lock: stable_cnt increments on each UPDATE with no change, saturating at LOCK_WINS;
//   locked=1 when stable_cnt==LOCK_WINS. Any change clears stable_cnt and locked on the same
//   edge as the trunc_pos change.
// - At POS_MAX with target above: hold, no pulse, counts as stable. Same at POS_MIN.
// - enable=0 in any state: next cycle IDLE. Partial window is discarded; trunc_pos keeps its
//   value; no pos_update.
// - enable re-asserted: reload from init_pos and start a fresh window.
// - rst mid-operation returns everything to reset values immediately.
// - Gaps in data_in_valid only stall win_cnt; the window length is in valid samples, not cycles.
// TESTING
// Config for all: DATA_I_WIDTH=30, DATA_O_WIDTH=12, WIN_LEN=16, HYST=0, LOCK_WINS=4.
// 1 Reset, enable=0 -> trunc_pos=29, locked=0, clip=0, pos_update=0.
// 2 Settle down: init_pos=29, enable=1, constant data_in=1000 (p=9, target clamps to 11)
//   -> trunc_pos steps 29..11, one step per 16 valid samples, 18 pos_update pulses;
//   locked=1 after 4 further windows.
// 3 Step up: from pos 11, feed 2^20 (p=20, target 21)
//   -> 10 increments to 21; locked drops at the first increment.
// 4 Clip at pos 11: +2047 -> clip=0; +2048 -> clip=1; -2048 -> clip=0; -2049 -> clip=1;
//   each visible one cycle after the sample.
// 5 Mid-window abort: drop enable after 7 samples, hold 3 cycles, re-enable with init_pos=5
//   -> trunc_pos=11 (clamped), no pulse from the aborted window, next update after 16 new samples.
// 6 Valid gaps plus UPDATE-cycle sample: toggle valid at 50% and assert valid during UPDATE
//   -> window boundaries fall every 16 valid samples exactly.

Source files
------------

// File: rtl/trunc_pos_agc_if.sv
// Sample/control bundle between the truncation-position controller and its source/sink.
interface trunc_pos_agc_if #(
   parameter int DATA_I_WIDTH = 30,
   parameter int POS_WIDTH    = $clog2(DATA_I_WIDTH)
);
   logic signed [DATA_I_WIDTH-1:0] data_in;
   logic                           data_in_valid;
   logic                           enable;
   logic        [POS_WIDTH-1:0]    init_pos;
   logic        [POS_WIDTH-1:0]    trunc_pos;
   logic                           pos_update;
   logic                           clip;
   logic                           locked;

   modport master (
      output data_in, data_in_valid, enable, init_pos,
      input  trunc_pos, pos_update, clip, locked
   );

   modport slave (
      input  data_in, data_in_valid, enable, init_pos,
      output trunc_pos, pos_update, clip, locked
   );
endinterface

// File: rtl/trunc_pos_agc.sv
// Windowed peak-magnitude tracker that nudges the truncator's MSB position one bit per window
// toward the tightest position that avoids clipping, with lock detection and per-sample clip flag.
module trunc_pos_agc #(
   parameter int DATA_I_WIDTH = 30,
   parameter int DATA_O_WIDTH = 12,
   parameter int POS_WIDTH    = $clog2(DATA_I_WIDTH),
   parameter int WIN_LEN      = 1024,
   parameter int HYST         = 0,
   parameter int LOCK_WINS    = 4
) (
   input logic            clk,
   input logic            rst,
   trunc_pos_agc_if.slave bus
);
   localparam int POS_MIN = DATA_O_WIDTH - 1;
   localparam int POS_MAX = DATA_I_WIDTH - 1;
   localparam int CW      = $clog2(WIN_LEN + 1);
   localparam int SW      = $clog2(LOCK_WINS + 1);

   typedef enum logic [1:0] {IDLE, MEASURE, UPDATE} state_t;

   state_t                  state;
   logic [POS_WIDTH-1:0]    pos;
   logic                    pos_update;
   logic                    clip;
   logic                    locked;
   logic [CW-1:0]           win_cnt;
   logic [DATA_I_WIDTH-1:0] peak;
   logic [SW-1:0]           stable_cnt;

   logic [DATA_I_WIDTH-1:0] mag;
   logic [POS_WIDTH-1:0]    p_in;
   logic [POS_WIDTH-1:0]    p_peak;
   logic [POS_WIDTH-1:0]    init_clamped;
   logic [POS_WIDTH-1:0]    pos_nxt;
   logic                    step_up;
   logic                    step_dn;
   int                      tgt;

   function automatic logic [POS_WIDTH-1:0] msb_idx(input logic [DATA_I_WIDTH-1:0] v);
      msb_idx = '0;
      for (int i = 0; i < DATA_I_WIDTH; i++)
         if (v[i]) msb_idx = POS_WIDTH'(i);
   endfunction

   function automatic logic [POS_WIDTH-1:0] clamp(input int v);
      if (v < POS_MIN)      clamp = POS_WIDTH'(POS_MIN);
      else if (v > POS_MAX) clamp = POS_WIDTH'(POS_MAX);
      else                  clamp = POS_WIDTH'(v);
   endfunction

   // One's-complement magnitude: -2^(N-1) maps to 2^(N-1)-1, so it never overflows.
   assign mag          = bus.data_in[DATA_I_WIDTH-1] ? ~bus.data_in : bus.data_in;
   assign p_in         = msb_idx(mag);
   assign p_peak       = msb_idx(peak);
   assign init_clamped = clamp(int'(bus.init_pos));

   always_comb begin
      tgt     = int'(clamp(int'(p_peak) + 1));
      step_up = tgt > int'(pos);
      step_dn = !step_up && (tgt + HYST < int'(pos));
      pos_nxt = pos;
      if (step_up)      pos_nxt = pos + 1'b1;
      else if (step_dn) pos_nxt = pos - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pos        <= POS_WIDTH'(POS_MAX);
         pos_update <= 1'b0;
         clip       <= 1'b0;
         locked     <= 1'b0;
         win_cnt    <= '0;
         peak       <= '0;
         stable_cnt <= '0;
      end else begin
         clip       <= bus.data_in_valid && (p_in >= pos);
         pos_update <= 1'b0;
         if (!bus.enable) begin
            // Partial window is dropped; position is held for the truncator.
            state      <= IDLE;
            win_cnt    <= '0;
            peak       <= '0;
            stable_cnt <= '0;
            locked     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state      <= MEASURE;
                  pos        <= init_clamped;
                  pos_update <= (init_clamped != pos);
                  win_cnt    <= '0;
                  peak       <= '0;
                  stable_cnt <= '0;
                  locked     <= 1'b0;
               end
               MEASURE: begin
                  if (bus.data_in_valid) begin
                     if (mag > peak) peak <= mag;
                     win_cnt <= win_cnt + 1'b1;
                     if (win_cnt == CW'(WIN_LEN - 1)) state <= UPDATE;
                  end
               end
               UPDATE: begin
                  state   <= MEASURE;
                  // A sample arriving now opens the next window.
                  peak    <= bus.data_in_valid ? mag : '0;
                  win_cnt <= bus.data_in_valid ? CW'(1) : '0;
                  if (step_up || step_dn) begin
                     pos        <= pos_nxt;
                     pos_update <= 1'b1;
                     stable_cnt <= '0;
                     locked     <= 1'b0;
                  end else begin
                     if (stable_cnt != SW'(LOCK_WINS)) stable_cnt <= stable_cnt + 1'b1;
                     locked <= (int'(stable_cnt) + 1 >= LOCK_WINS);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.trunc_pos  = pos;
   assign bus.pos_update = pos_update;
   assign bus.clip       = clip;
   assign bus.locked     = locked;
endmodule

// File: tb/tb_trunc_pos_agc.sv
// Directed bench for trunc_pos_agc: stimulus queues expected positions and clip flags,
// a negedge monitor pops them as the DUT pulses pos_update or reports clip.
module tb_trunc_pos_agc;
   localparam int DW = 30;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   trunc_pos_agc_if #(.DATA_I_WIDTH(DW)) bus ();

   trunc_pos_agc #(
      .DATA_I_WIDTH(DW), .DATA_O_WIDTH(12), .WIN_LEN(16), .HYST(0), .LOCK_WINS(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {bit chk; bit exp;} clip_exp_t;

   int        nvec = 0;
   int        nerr = 0;
   int        pulses = 0;
   int        pos_q[$];
   clip_exp_t clip_q[$];
   clip_exp_t ce;
   logic      vld_q;

   task automatic check(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: decoupled from stimulus, consumes expectations as the DUT presents outputs.
   always @(posedge clk) vld_q <= rst ? 1'b0 : bus.data_in_valid;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.pos_update) begin
            pulses++;
            if (pos_q.size() == 0) check("pos_update with nothing queued", pos_q.size(), 1);
            else                   check("trunc_pos at pos_update", int'(bus.trunc_pos), pos_q.pop_front());
         end
         if (vld_q) begin
            if (clip_q.size() == 0) check("clip without queued sample", clip_q.size(), 1);
            else begin
               ce = clip_q.pop_front();
               if (ce.chk) check("clip", int'(bus.clip), int'(ce.exp));
            end
         end else begin
            check("clip after invalid cycle", int'(bus.clip), 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.data_in_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send(input int val, input int n, input bit gap, input bit chk, input bit exp);
      clip_exp_t e;
      for (int i = 0; i < n; i++) begin
         e.chk = chk;
         e.exp = exp;
         clip_q.push_back(e);
         bus.data_in       = DW'(val);
         bus.data_in_valid = 1'b1;
         tick();
         if (gap) idle(1);
      end
   endtask

   initial begin
      int p0;
      bus.data_in       = '0;
      bus.data_in_valid = 1'b0;
      bus.enable        = 1'b0;
      bus.init_pos      = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      tick();

      // 1: reset state
      check("reset trunc_pos", int'(bus.trunc_pos), 29);
      check("reset locked", int'(bus.locked), 0);
      check("reset clip", int'(bus.clip), 0);
      check("reset pos_update", int'(bus.pos_update), 0);

      // 2: settle down from 29 to the floor of 11 with p=9 data
      for (int p = 28; p >= 11; p--) pos_q.push_back(p);
      bus.init_pos = 5'd29;
      bus.enable   = 1'b1;
      tick();
      check("load trunc_pos", int'(bus.trunc_pos), 29);
      check("load no pulse", int'(bus.pos_update), 0);
      send(1000, 336, 0, 1, 0);
      idle(3);
      check("settle trunc_pos", int'(bus.trunc_pos), 11);
      check("settle pulses", pulses, 18);
      check("locked after 3 stable", int'(bus.locked), 0);
      send(1000, 16, 0, 1, 0);
      idle(2);
      check("locked after 4 stable", int'(bus.locked), 1);

      // 4: clip thresholds at pos 11, controller idle
      bus.enable = 1'b0;
      idle(2);
      check("idle drops locked", int'(bus.locked), 0);
      check("idle holds trunc_pos", int'(bus.trunc_pos), 11);
      send(2047, 1, 1, 1, 0);
      send(2048, 1, 1, 1, 1);
      send(-2048, 1, 1, 1, 0);
      send(-2049, 1, 1, 1, 1);

      // 5: mid-window abort, reload with clamped init_pos
      p0 = pulses;
      bus.init_pos = 5'd5;
      bus.enable   = 1'b1;
      idle(1);
      check("clamped load", int'(bus.trunc_pos), 11);
      send(1 << 20, 7, 0, 1, 1);
      bus.enable = 1'b0;
      idle(3);
      bus.enable = 1'b1;
      idle(1);
      check("reload trunc_pos", int'(bus.trunc_pos), 11);
      check("no pulse from abort", pulses - p0, 0);
      send(1 << 20, 15, 0, 1, 1);
      idle(3);
      check("no update at 15 samples", int'(bus.trunc_pos), 11);
      pos_q.push_back(12);
      send(1 << 20, 1, 0, 1, 1);
      idle(2);
      check("update at 16 samples", int'(bus.trunc_pos), 12);

      // 6: 50% valid gaps, sample during UPDATE opens the next window
      pos_q.push_back(11);
      send(1000, 15, 1, 1, 0);
      send(1000, 1, 0, 1, 0);
      send(1 << 20, 1, 0, 1, 1);
      check("gapped window step down", int'(bus.trunc_pos), 11);
      pos_q.push_back(12);
      send(1000, 14, 1, 1, 0);
      idle(2);
      check("window incl UPDATE sample not done", int'(bus.trunc_pos), 11);
      send(1000, 1, 0, 1, 0);
      idle(2);
      check("UPDATE-cycle sample peak counted", int'(bus.trunc_pos), 12);
      pos_q.push_back(11);
      send(1000, 80, 0, 1, 0);
      idle(2);
      check("relock trunc_pos", int'(bus.trunc_pos), 11);
      check("relock locked", int'(bus.locked), 1);

      // 3: step up 11 -> 21 with p=20 data
      for (int w = 0; w < 10; w++) begin
         pos_q.push_back(12 + w);
         send(1 << 20, 16, 0, 1, 1);
         idle(2);
         check("step up trunc_pos", int'(bus.trunc_pos), 12 + w);
         if (w == 0) check("locked drops on change", int'(bus.locked), 0);
      end
      send(1 << 20, 64, 0, 1, 0);
      idle(2);
      check("top hold trunc_pos", int'(bus.trunc_pos), 21);
      check("top hold locked", int'(bus.locked), 1);

      idle(2);
      check("pending pos expectations", pos_q.size(), 0);
      check("pending clip expectations", clip_q.size(), 0);
      check("total pulses", pulses, 32);

      // Asynchronous reset mid-operation
      #2 rst = 1'b1;
      #1;
      check("async reset trunc_pos", int'(bus.trunc_pos), 29);
      check("async reset locked", int'(bus.locked), 0);
      check("async reset pos_update", int'(bus.pos_update), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
